// File: rtl/auth_challenge_engine.sv
// auth_challenge_engine: challenge-response authenticator with failure counting and permanent lockout
//   clk, reset (async, active-low)
//   challenge_in[15:0] : live LFSR word captured on an accepted start
//   start              : begin a round (accepted only in IDLE or DONE)
//   rsp_valid, rsp_byte: response bytes, high byte first
//   chal_valid, chal_byte : challenge bytes streamed out, high byte first
//   busy, pass, fail, locked, fail_cnt[3:0] : round status
module auth_challenge_engine #(
    parameter logic [15:0] KEY       = 16'hA5C3,
    parameter int          MAX_FAILS = 3,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] challenge_in,
    input  logic        start,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_byte,
    output logic        chal_valid,
    output logic [7:0]  chal_byte,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic        locked,
    output logic [3:0]  fail_cnt
);
    typedef enum logic [2:0] {IDLE, CHAL_HI, CHAL_LO, WAIT_HI, WAIT_LO, CHECK, DONE, LOCK} state_t;
    localparam logic [3:0] MAXF = 4'(MAX_FAILS);
    localparam logic [7:0] TMO  = 8'(TIMEOUT);
    state_t      state;
    logic [15:0] c, r, e;
    logic [7:0]  tmo;
    logic [3:0]  fail_next;
    logic        waiting, go_fail;
    assign e         = {c[12:0], c[15:13]} ^ KEY;
    assign fail_next = fail_cnt + 4'd1;
    assign waiting   = (state == WAIT_HI) || (state == WAIT_LO);
    // a mismatch in CHECK and a response timeout share one fail path
    assign go_fail   = ((state == CHECK) && (r != e)) ||
                       (waiting && !rsp_valid && (tmo == TMO - 8'd1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            c          <= '0;
            r          <= '0;
            tmo        <= '0;
            chal_valid <= 1'b0;
            chal_byte  <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            locked     <= 1'b0;
            fail_cnt   <= '0;
        end else if (go_fail) begin
            fail     <= 1'b1;
            busy     <= 1'b0;
            fail_cnt <= fail_next;
            locked   <= (fail_next == MAXF);
            state    <= (fail_next == MAXF) ? LOCK : DONE;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    c          <= challenge_in;
                    pass       <= 1'b0;
                    fail       <= 1'b0;
                    busy       <= 1'b1;
                    chal_valid <= 1'b1;
                    chal_byte  <= challenge_in[15:8];
                    state      <= CHAL_HI;
                end
                CHAL_HI: begin
                    chal_byte <= c[7:0];
                    state     <= CHAL_LO;
                end
                CHAL_LO: begin
                    chal_valid <= 1'b0;
                    chal_byte  <= '0;
                    tmo        <= '0;
                    state      <= WAIT_HI;
                end
                WAIT_HI: if (rsp_valid) begin
                    r[15:8] <= rsp_byte;
                    tmo     <= '0;
                    state   <= WAIT_LO;
                end else begin
                    tmo <= tmo + 8'd1;
                end
                WAIT_LO: if (rsp_valid) begin
                    r[7:0] <= rsp_byte;
                    state  <= CHECK;
                end else begin
                    tmo <= tmo + 8'd1;
                end
                // only a match reaches here; mismatches leave through go_fail
                CHECK: begin
                    pass     <= 1'b1;
                    fail_cnt <= '0;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_auth_challenge_engine.sv
// tb_auth_challenge_engine: scoreboard bench for auth_challenge_engine using directed vectors
module tb_auth_challenge_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] challenge_in = '0;
    logic        start = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_byte = '0;
    logic        chal_valid, busy, pass, fail, locked;
    logic [7:0]  chal_byte;
    logic [3:0]  fail_cnt;

    typedef struct {
        bit          kind;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    logic prev_res = 1'b0;

    auth_challenge_engine dut (
        .clk(clk), .reset(reset), .challenge_in(challenge_in), .start(start),
        .rsp_valid(rsp_valid), .rsp_byte(rsp_byte), .chal_valid(chal_valid),
        .chal_byte(chal_byte), .busy(busy), .pass(pass), .fail(fail),
        .locked(locked), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // result word: {pass, fail, locked, fail_cnt}
    function automatic logic [15:0] res(input logic p, input logic f, input logic l, input logic [3:0] n);
        return {9'h0, p, f, l, n};
    endfunction

    // monitor: every presented challenge byte and every new result is checked against the queue
    always @(negedge clk) begin
        exp_t it;
        if (reset === 1'b1) begin
            if (chal_valid) begin
                if (sbq.size() == 0 || sbq[0].kind != 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL chal_unexpected: got byte %h expected no challenge byte", chal_byte);
                end else begin
                    it = sbq.pop_front();
                    chk("chal_byte", {24'h0, chal_byte}, {16'h0, it.val});
                end
            end
            if ((pass | fail) && !prev_res) begin
                if (sbq.size() == 0 || sbq[0].kind != 1'b1) begin
                    total++;
                    bad++;
                    $display("FAIL result_unexpected: got %b%b%b/%0d expected none", pass, fail, locked, fail_cnt);
                end else begin
                    it = sbq.pop_front();
                    chk("result", {16'h0, res(pass, fail, locked, fail_cnt)}, {16'h0, it.val});
                end
            end
            prev_res = pass | fail;
        end else begin
            prev_res = 1'b0;
        end
    end

    task automatic push_chal(input logic [15:0] ch);
        sbq.push_back('{1'b0, {8'h0, ch[15:8]}});
        sbq.push_back('{1'b0, {8'h0, ch[7:0]}});
    endtask

    task automatic begin_round(input logic [15:0] ch);
        challenge_in = ch;
        push_chal(ch);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'h0, busy}, 32'd1);
        chk("start_clears", {30'h0, pass, fail}, 32'd0);
        tick();
        tick();
    endtask

    task automatic run_round(input logic [15:0] ch, input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp_res);
        begin_round(ch);
        rsp_valid = 1'b1;
        rsp_byte = hi;
        tick();
        rsp_byte = lo;
        sbq.push_back('{1'b1, exp_res});
        tick();
        rsp_valid = 1'b0;
        chk("busy_in_check", {31'h0, busy}, 32'd1);
        tick();
        chk("result_latency", {31'h0, pass | fail}, 32'd1);
        chk("idle_after_result", {31'h0, busy}, 32'd0);
    endtask

    task automatic all_zero(input string nm);
        chk(nm, {17'h0, chal_valid, chal_byte, busy, pass, fail, locked, fail_cnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #2;
        all_zero("reset_outputs");
        tick();
        tick();
        reset = 1'b1;
        tick();

        run_round(16'h2359, 8'hBF, 8'h0A, res(1, 0, 0, 0));
        run_round(16'h2359, 8'hBF, 8'h0B, res(0, 1, 0, 1));
        run_round(16'h0000, 8'hA5, 8'hC3, res(1, 0, 0, 0));
        run_round(16'hFFFF, 8'h5A, 8'h3C, res(1, 0, 0, 0));
        run_round(16'h8001, 8'hA5, 8'hCF, res(1, 0, 0, 0));

        run_round(16'h1234, 8'h00, 8'h00, res(0, 1, 0, 1));
        run_round(16'h1234, 8'h00, 8'h00, res(0, 1, 0, 2));
        run_round(16'h1234, 8'h00, 8'h00, res(0, 1, 1, 3));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("lock_held", {26'h0, busy, fail, locked, fail_cnt}, {26'h0, 1'b0, 1'b1, 1'b1, 4'd3});

        reset = 1'b0;
        #1;
        all_zero("reset_clears_lock");
        tick();
        reset = 1'b1;
        tick();

        begin_round(16'h4C4C);
        sbq.push_back('{1'b1, res(0, 1, 0, 1)});
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            start = (i == 10);
            tick();
            start = 1'b0;
            if (i == 10) chk("start_ignored_busy", {31'h0, busy}, 32'd1);
            if (fail) begin
                k = i;
                break;
            end
        end
        chk("timeout_edges", k, 32'd255);

        begin_round(16'h2359);
        rsp_valid = 1'b1;
        rsp_byte = 8'hBF;
        tick();
        rsp_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        all_zero("reset_mid_round");
        tick();
        reset = 1'b1;
        tick();
        run_round(16'h2359, 8'hBF, 8'h0A, res(1, 0, 0, 0));

        for (int i = 0; i < 3; i++) tick();
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/auth_challenge_engine.md
# auth_challenge_engine

Challenge-response authenticator that sits directly downstream of the 16-bit LFSR nonce generator. On `start` it captures the current LFSR word as the challenge and streams it out as two bytes. It then collects a two-byte response and compares it against a keyed transform of the challenge. It reports pass or fail, counts consecutive failures and enters a permanent lockout after too many failures.

## Interface
- `KEY`, 16'hA5C3, secret key used in the response transform
- `MAX_FAILS`, 3, consecutive failures that cause lockout (1..15)
- `TIMEOUT`, 255, max idle cycles allowed while waiting for each response byte (1..255)

- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-low
- `challenge_in` in 16: live LFSR output
- `start` in 1: request a new authentication round
- `rsp_valid` in 1: `rsp_byte` is valid this cycle
- `rsp_byte` in 8: response byte, high byte first
- `chal_valid` out 1: `chal_byte` is valid this cycle
- `chal_byte` out 8: challenge byte, high byte first
- `busy` out 1: a round is in progress
- `pass` out 1: last round matched; held until the next accepted `start`
- `fail` out 1: last round mismatched or timed out; held until the next accepted `start`
- `locked` out 1: lockout active
- `fail_cnt` out 4: consecutive failure count

## Operation
- States: IDLE, CHAL_HI, CHAL_LO, WAIT_HI, WAIT_LO, CHECK, DONE, LOCK.
- Reset values: all outputs 0, state IDLE, challenge and response registers 0.
- When `start` is sampled high in IDLE or DONE:
  - capture `challenge_in` into register C;
  - clear `pass` and `fail`;
  - go to CHAL_HI.
- `start` is ignored in every other state.
- CHAL_HI drives `chal_valid`=1 and `chal_byte`=C[15:8], then goes to CHAL_LO.
- CHAL_LO drives `chal_valid`=1 and `chal_byte`=C[7:0], then goes to WAIT_HI.
- Outside CHAL_HI and CHAL_LO: `chal_valid`=0 and `chal_byte`=0.
- WAIT_HI: when `rsp_valid`=1, latch R[15:8] and go to WAIT_LO.
- WAIT_LO: when `rsp_valid`=1, latch R[7:0] and go to CHECK.
- `rsp_valid` is ignored in all states except WAIT_HI and WAIT_LO.
- Timeout counter:
  - clears on entry to each WAIT state;
  - increments on every WAIT cycle without `rsp_valid`;
  - if it reaches TIMEOUT, the round fails immediately and goes straight to the fail path, skipping CHECK.
- CHECK computes the expected response E = {C[12:0], C[15:13]} ^ KEY, a 16-bit rotate-left by 3 followed by XOR. It is pure 16-bit logic with no carries.
- On a match (R==E):
  - `pass`=1;
  - `fail_cnt` cleared to 0;
  - go to DONE.
- On a mismatch or timeout:
  - `fail`=1;
  - `fail_cnt` incremented;
  - if the new count equals MAX_FAILS, go to LOCK, otherwise go to DONE.
- `busy`=1 in CHAL_HI, CHAL_LO, WAIT_HI, WAIT_LO and CHECK; `busy`=0 otherwise.
- LOCK:
  - `locked`=1 and `fail`=1, held;
  - `fail_cnt` is held at MAX_FAILS;
  - `start` is ignored;
  - only `reset` exits.
- Reset asserted at any point, including mid-round, immediately returns every register to its reset value; the partial round is discarded.

## Timing
- `start` sampled at edge N:
  - high byte visible (`chal_valid`=1) in the cycle after N;
  - low byte visible in the cycle after N+1;
  - WAIT_HI begins after edge N+2.
- A response byte is accepted on the same edge `rsp_valid` is sampled high. Back-to-back bytes on consecutive cycles are accepted.
- Low byte accepted at edge E:
  - CHECK occupies the following cycle;
  - `pass`/`fail` and `fail_cnt` update at edge E+1.
- Minimum round, `start` to result: 5 edges.
- Timeout: with no `rsp_valid`, `fail` rises TIMEOUT edges after entry to that WAIT state.
- `start` sampled high in DONE in the same cycle a result is showing: it is accepted, and the result clears at that edge.

## Test plan
- Reset, then `challenge_in`=16'h2359, pulse `start` -> `chal_byte` 8'h23 then 8'h59 on consecutive cycles, `busy`=1.
- Send response bytes 8'hBF, 8'h0A -> `pass`=1 two edges after the second byte, `fail_cnt`=0, `busy`=0.
- Same challenge, respond 8'hBF, 8'h0B -> `fail`=1, `fail_cnt`=1; the next `start` clears `fail`.
- Three consecutive wrong rounds -> `locked`=1, `fail_cnt`=3; a further `start` produces no `chal_valid`; after `reset`, `locked`=0 and `fail_cnt`=0.
- Send no response after the challenge -> `fail`=1 exactly TIMEOUT edges after entering WAIT_HI; a `start` pulsed while `busy`=1 is ignored.
- Assert `reset` during WAIT_LO -> all outputs 0 immediately; the next round behaves normally and 8'hBF/8'h0A passes.
